packet_gen_v2: RTL and testbench
================================

Name: packet_gen_v2

Overview:
- Parametrised successor AXI4-Stream traffic generator for 100GbE bring-up and loopback testing.
- Emits N packets, or runs continuously until stopped, with configurable gap cycles.
- Lengths are fixed or swept min->max in steps; payload is a rolling counter, PRBS or constant, with an optional 32-bit sequence-number header.
- Keeps packet/byte statistics. Sits between AXI-Lite config registers and the MAC TX stream.

Parameters:
DW, 512, tdata width in bits; multiple of 32, >=64
LEN_W, 16, width of packet-length fields in bytes
CNT_W, 32, width of packet_count and pkts_sent

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
stop  in  1  one-cycle pulse; graceful stop request
packet_count  in  CNT_W  packets per run; 0 = continuous until stop
min_len  in  LEN_W  first/minimum packet length in bytes
max_len  in  LEN_W  sweep ceiling in bytes
len_step  in  LEN_W  sweep increment in bytes; 0 = fixed length min_len
idle_cycles  in  16  tvalid-low cycles between packets
data_mode  in  2  0=counter, 1=PRBS32, 2=constant, 3=reserved (behaves as 0)
seed  in  32  counter initial value [15:0] / PRBS seed / constant word
hdr_en  in  1  overwrite tdata[31:0] of first beat with sequence number
busy  out  1  high from start acceptance until run ends
pkts_sent  out  CNT_W  packets completed this run
bytes_sent  out  48  bytes completed this run
axis_out_tdata  out  DW  stream data
axis_out_tkeep  out  DW/8  byte enables, low-order contiguous
axis_out_tlast  out  1  last beat of packet
axis_out_tvalid  out  1  data valid
axis_out_tready  in  1  downstream ready

Behaviour:
- Reset: state IDLE; busy, tvalid, tlast = 0; pkts_sent, bytes_sent = 0. Reset mid-packet aborts immediately: tvalid is 0 on the next cycle; no partial-packet completion.
- FSM states IDLE, SEND, GAP.
- IDLE: start with stop low latches all config inputs (changes during a run are ignored) and clears stats; SEND next cycle. busy is combinationally high the cycle start is seen.
- start and stop in the same IDLE cycle: stop wins; no run begins. start while busy is ignored.
- SEND: tvalid = 1, independent of tready. tdata, tkeep, tlast are held stable while tvalid && !tready. A beat completes on tvalid && tready.
- Beats per packet = ceil(len/(DW/8)). tlast on the final beat. tkeep is all ones except on a partial final beat, where it equals (1<<(len mod DW/8))-1. Latched length 0 is treated as 1.
- On the tlast handshake: pkts_sent += 1; bytes_sent += len (both wrap).
  - Run ends (-> IDLE) if packet_count != 0 and pkts_sent reaches packet_count, or a stop is pending.
  - Otherwise -> GAP if idle_cycles != 0, else SEND back-to-back with no bubble.
- GAP: exactly idle_cycles cycles with tvalid = 0, then SEND.
- stop: latched as stop_pending in any busy cycle.
  - In GAP: IDLE next cycle.
  - In SEND: the current packet completes, then IDLE.
  - Cleared on entry to IDLE.
- Length sweep: cur_len starts at min_len. After each packet, next = cur_len + len_step computed at LEN_W+1 bits; if next > max_len, cur_len = min_len, else cur_len = next. max_len < min_len is treated as fixed min_len.
- Patterns advance once per accepted beat and are continuous across packets and gaps:
  - counter: 16-bit value replicated DW/16 times; initial value seed[15:0]; +1 per beat.
  - PRBS32: Galois LFSR, polynomial 0x80200003, shifting right with XOR when LSB = 1. Its 32-bit state is replicated DW/32 times. Seed 0 is replaced by 1.
  - constant: seed replicated DW/32 times; never changes.
- hdr_en: tdata[31:0] of beat 1 of every packet = packet sequence number (0,1,2,... per run). This does not alter pattern advance.

Decomposition:
- Shared package pktgen_pkg:
  - data_mode encodings MODE_COUNTER/MODE_PRBS/MODE_CONST
  - PRBS_POLY = 32'h80200003
  - function prbs_next
  - state encodings
- Sub-module pktgen_pattern: holds the counter/LFSR state; inputs init, advance, mode, seed; output DW-bit pattern.

Test Plan:
- count=3, min_len=100, step=0, gap=0, counter mode, seed=0x0010, tready=1 -> 6 beats with no bubbles; beat 2 of each packet has tkeep=0x0000000FFFFFFFFF; words 0x0010..0x0015; pkts_sent=3, bytes_sent=300.
- count=5, min=64, max=200, step=64 -> lengths 64,128,192,64,128; beats 1,2,3,1,2; bytes_sent=576.
- Same as the first scenario with random 50% tready -> tdata/tkeep/tlast stable during every stall; stream identical to the first scenario once stalls are removed.
- count=0, len=64, gap=4, stop pulsed mid-packet 2 -> packet 2 completes; no packet 3; exactly 4 tvalid-low cycles between packets 1 and 2; busy falls after the packet-2 tlast handshake.
- PRBS mode, seed=0, hdr_en=1, count=3, len=128 -> state starts at 1; first-beat tdata[31:0] = 0,1,2; remaining lanes match the reference LFSR model.
- Reset asserted mid-packet 2 -> tvalid=0 next cycle, stats zero; a new start runs a clean sequence from seq 0.

Source files
------------

// File: rtl/pktgen_pkg.sv
// Shared encodings and helpers for the packet generator.
package pktgen_pkg;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_PRBS    = 2'd1;
  localparam logic [1:0] MODE_CONST   = 2'd2;

  localparam logic [31:0] PRBS_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ PRBS_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/packet_gen_v2_if.sv
// AXI4-Stream bundle carried from the generator to the MAC.
interface packet_gen_v2_if #(
  parameter int unsigned DW = 512
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/pktgen_pattern.sv
// Payload pattern source: rolling counter, PRBS32 or constant, stepped once per beat.
module pktgen_pattern
  import pktgen_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          advance,
  input  logic [1:0]    mode,
  input  logic [31:0]   seed,
  output logic [DW-1:0] pattern
);

  logic [15:0] cnt_q, cnt_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] const_q, const_d;

  // Pattern state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      lfsr_q  <= 32'd1;
      const_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      const_q <= const_d;
    end
  end

  // Load from seed at run start; otherwise both generators step on every accepted beat.
  always_comb begin
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    const_d = const_q;
    if (init) begin
      cnt_d   = seed[15:0];
      lfsr_d  = (seed == 32'd0) ? 32'd1 : seed;
      const_d = seed;
    end else if (advance) begin
      cnt_d  = cnt_q + 16'd1;
      lfsr_d = prbs_next(lfsr_q);
    end
  end

  // Lane replication of the selected generator; reserved mode falls back to counter.
  always_comb begin
    case (mode)
      MODE_PRBS:  pattern = {(DW/32){lfsr_q}};
      MODE_CONST: pattern = {(DW/32){const_q}};
      default:    pattern = {(DW/16){cnt_q}};
    endcase
  end

endmodule

// File: rtl/packet_gen_v2.sv
// AXI4-Stream traffic generator: counted or continuous runs, length sweep, gaps, statistics.
module packet_gen_v2
  import pktgen_pkg::*;
#(
  parameter int unsigned DW    = 512,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] packet_count,
  input  logic [LEN_W-1:0] min_len,
  input  logic [LEN_W-1:0] max_len,
  input  logic [LEN_W-1:0] len_step,
  input  logic [15:0]      idle_cycles,
  input  logic [1:0]       data_mode,
  input  logic [31:0]      seed,
  input  logic             hdr_en,
  output logic             busy,
  output logic [CNT_W-1:0] pkts_sent,
  output logic [47:0]      bytes_sent,
  packet_gen_v2_if.master  axis_out
);

  localparam int unsigned Bytes = DW / 8;

  state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, pkts_q, pkts_d;
  logic [LEN_W-1:0] min_q, min_d, max_q, max_d, step_q, step_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d, rem_q, rem_d;
  logic [15:0]      idle_q, idle_d, gap_q, gap_d;
  logic [1:0]       mode_q, mode_d;
  logic             hdr_q, hdr_d, first_q, first_d, stop_pend_q, stop_pend_d;
  logic [47:0]      bytes_q, bytes_d;

  logic             accept, beat, last, pkt_done, stop_any, run_end;
  logic [CNT_W-1:0] pkts_inc;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] next_len;
  logic [DW-1:0]    pattern;
  logic             tvalid;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  assign accept   = (state_q == StIdle) && start && !stop;
  assign tvalid   = (state_q == StSend);
  assign beat     = tvalid && axis_out.tready;
  assign last     = (rem_q <= LEN_W'(Bytes));
  assign pkt_done = beat && last;
  assign stop_any = stop_pend_q || stop;
  assign pkts_inc = pkts_q + CNT_W'(1);
  assign run_end  = ((count_q != '0) && (pkts_inc == count_q)) || stop_any;
  // Sum one bit wider so a step past the top of the range wraps back to min.
  assign len_sum  = {1'b0, cur_len_q} + {1'b0, step_q};
  assign next_len = ((max_q < min_q) || (len_sum > {1'b0, max_q})) ? min_q : len_sum[LEN_W-1:0];

  pktgen_pattern #(
    .DW (DW)
  ) u_pattern (
    .clk     (clk),
    .reset   (reset),
    .init    (accept),
    .advance (beat),
    .mode    (mode_q),
    .seed    (seed),
    .pattern (pattern)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pkts_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      step_q      <= '0;
      cur_len_q   <= '0;
      rem_q       <= '0;
      idle_q      <= '0;
      gap_q       <= '0;
      mode_q      <= MODE_COUNTER;
      hdr_q       <= 1'b0;
      first_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pkts_q      <= pkts_d;
      min_q       <= min_d;
      max_q       <= max_d;
      step_q      <= step_d;
      cur_len_q   <= cur_len_d;
      rem_q       <= rem_d;
      idle_q      <= idle_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      hdr_q       <= hdr_d;
      first_q     <= first_d;
      stop_pend_q <= stop_pend_d;
      bytes_q     <= bytes_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: begin
        if (pkt_done) begin
          if (run_end)             state_d = StIdle;
          else if (idle_q != '0)   state_d = StGap;
        end
      end
      StGap: begin
        if (stop_any)            state_d = StIdle;
        else if (gap_q <= 16'd1) state_d = StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  // Config latch, beat/byte accounting, length sweep and gap countdown.
  always_comb begin
    count_d     = count_q;
    pkts_d      = pkts_q;
    min_d       = min_q;
    max_d       = max_q;
    step_d      = step_q;
    cur_len_d   = cur_len_q;
    rem_d       = rem_q;
    idle_d      = idle_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    hdr_d       = hdr_q;
    first_d     = first_q;
    stop_pend_d = stop_pend_q;
    bytes_d     = bytes_q;

    if (accept) begin
      count_d   = packet_count;
      min_d     = min_len;
      max_d     = max_len;
      step_d    = len_step;
      idle_d    = idle_cycles;
      mode_d    = data_mode;
      hdr_d     = hdr_en;
      cur_len_d = min_len;
      rem_d     = eff_len(min_len);
      first_d   = 1'b1;
      pkts_d    = '0;
      bytes_d   = '0;
    end

    if ((state_q != StIdle) && stop) stop_pend_d = 1'b1;

    if (beat) begin
      if (last) begin
        pkts_d    = pkts_inc;
        bytes_d   = bytes_q + 48'(eff_len(cur_len_q));
        cur_len_d = next_len;
        rem_d     = eff_len(next_len);
        first_d   = 1'b1;
        gap_d     = idle_q;
      end else begin
        rem_d   = rem_q - LEN_W'(Bytes);
        first_d = 1'b0;
      end
    end

    if (state_q == StGap) gap_d = gap_q - 16'd1;

    if ((state_q != StIdle) && (state_d == StIdle)) stop_pend_d = 1'b0;
  end

  // Stream outputs derive from held state, so they stay stable while stalled.
  always_comb begin
    axis_out.tvalid = tvalid;
    axis_out.tlast  = tvalid && last;
    axis_out.tdata  = pattern;
    if (hdr_q && first_q) axis_out.tdata[31:0] = 32'(pkts_q);
    for (int i = 0; i < int'(Bytes); i++) begin
      axis_out.tkeep[i] = !last || (LEN_W'(unsigned'(i)) < rem_q);
    end
    busy       = (state_q != StIdle) || accept;
    pkts_sent  = pkts_q;
    bytes_sent = bytes_q;
  end

endmodule

// File: tb/tb_packet_gen_v2.sv
// Scoreboard bench for packet_gen_v2: expected beats queued by a model, popped on handshakes.
module tb_packet_gen_v2;
  import pktgen_pkg::*;

  localparam int DW    = 512;
  localparam int LEN_W = 16;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic            last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset, start, stop, hdr_en;
  logic [CNT_W-1:0] packet_count;
  logic [LEN_W-1:0] min_len, max_len, len_step;
  logic [15:0]      idle_cycles;
  logic [1:0]       data_mode;
  logic [31:0]      seed;
  logic             busy;
  logic [CNT_W-1:0] pkts_sent;
  logic [47:0]      bytes_sent;

  packet_gen_v2_if #(.DW(DW)) axis_out ();

  packet_gen_v2 #(
    .DW    (DW),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .packet_count (packet_count),
    .min_len      (min_len),
    .max_len      (max_len),
    .len_step     (len_step),
    .idle_cycles  (idle_cycles),
    .data_mode    (data_mode),
    .seed         (seed),
    .hdr_en       (hdr_en),
    .busy         (busy),
    .pkts_sent    (pkts_sent),
    .bytes_sent   (bytes_sent),
    .axis_out     (axis_out)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];

  // Reference pattern model.
  logic [15:0] m_cnt;
  logic [31:0] m_lfsr, m_const;
  logic [1:0]  m_mode;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic model_init(input logic [1:0] mode, input logic [31:0] sd);
    m_mode  = mode;
    m_cnt   = sd[15:0];
    m_lfsr  = (sd == 0) ? 32'd1 : sd;
    m_const = sd;
  endtask

  task automatic push_pkt(input int len, input int seq, input bit hdr);
    int l;
    int nb;
    int r;
    l  = (len == 0) ? 1 : len;
    nb = (l + DW/8 - 1) / (DW/8);
    r  = l % (DW/8);
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      case (m_mode)
        2'd1:    e.data = {(DW/32){m_lfsr}};
        2'd2:    e.data = {(DW/32){m_const}};
        default: e.data = {(DW/16){m_cnt}};
      endcase
      if (hdr && b == 0) e.data[31:0] = seq;
      e.keep = (b == nb - 1 && r != 0) ? ((64'd1 << r) - 64'd1) : {(DW/8){1'b1}};
      e.last = (b == nb - 1);
      exp_q.push_back(e);
      m_cnt  = m_cnt + 16'd1;
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // Scoreboard monitor: every handshake pops an expectation; stalls must hold the beat.
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge clk) begin
    beat_t act;
    act.data = axis_out.tdata;
    act.keep = axis_out.tkeep;
    act.last = axis_out.tlast;
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        if (act !== prev_beat || axis_out.tvalid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold act data=%h keep=%h last=%b held data=%h keep=%h last=%b",
                   act.data, act.keep, act.last, prev_beat.data, prev_beat.keep, prev_beat.last);
        end
      end
      if (axis_out.tvalid && axis_out.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat act data=%h last=%b required no beat", act.data, act.last);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat act data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                     act.data, act.keep, act.last, e.data, e.keep, e.last);
          end
        end
      end
      prev_stall = axis_out.tvalid && !axis_out.tready;
      prev_beat  = act;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cfg(input int cnt, input int mn, input int mx, input int st, input int gap,
                     input logic [1:0] mode, input logic [31:0] sd, input bit hdr);
    packet_count = cnt;
    min_len      = mn[LEN_W-1:0];
    max_len      = mx[LEN_W-1:0];
    len_step     = st[LEN_W-1:0];
    idle_cycles  = gap[15:0];
    data_mode    = mode;
    seed         = sd;
    hdr_en       = hdr;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits until the scoreboard empties; counts tvalid-low cycles once streaming began.
  task automatic wait_drain(input int budget, output int bubbles);
    bit seen;
    seen    = 1'b0;
    bubbles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (axis_out.tvalid) seen = 1'b1;
      else if (seen) bubbles++;
      if (exp_q.size() == 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, axis_out.tvalid, axis_out.tlast} !== 3'b000 || pkts_sent !== 0 || bytes_sent !== 0) begin
      errors++;
      $display("FAIL reset_state act busy=%b tvalid=%b tlast=%b pkts=%0d bytes=%0d required all 0",
               busy, axis_out.tvalid, axis_out.tlast, pkts_sent, bytes_sent);
    end
    reset = 1'b0;
  endtask

  task automatic test_fixed_len();
    int bub;
    cfg(3, 100, 100, 0, 0, MODE_COUNTER, 32'h0010, 1'b0);
    model_init(MODE_COUNTER, 32'h0010);
    for (int p = 0; p < 3; p++) push_pkt(100, p, 1'b0);
    axis_out.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_start act=%b required=1", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(100, bub);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fixed_timeout act left=%0d required 0", exp_q.size());
    end
    checks++;
    if (bub !== 0) begin
      errors++;
      $display("FAIL fixed_bubbles act=%0d required=0", bub);
    end
    @(posedge clk); #1;
    checks++;
    if (pkts_sent !== 3 || bytes_sent !== 300 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fixed_stats act pkts=%0d bytes=%0d busy=%b required 3 300 0",
               pkts_sent, bytes_sent, busy);
    end
  endtask

  task automatic test_sweep();
    int bub;
    int lens[5] = '{64, 128, 192, 64, 128};
    cfg(5, 64, 200, 64, 0, MODE_COUNTER, 32'h1000, 1'b0);
    model_init(MODE_COUNTER, 32'h1000);
    foreach (lens[i]) push_pkt(lens[i], i, 1'b0);
    do_start();
    wait_drain(200, bub);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_timeout act left=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (pkts_sent !== 5 || bytes_sent !== 576) begin
      errors++;
      $display("FAIL sweep_stats act pkts=%0d bytes=%0d required 5 576", pkts_sent, bytes_sent);
    end
  endtask

  task automatic test_stall();
    cfg(3, 100, 100, 0, 0, MODE_COUNTER, 32'h0010, 1'b0);
    model_init(MODE_COUNTER, 32'h0010);
    for (int p = 0; p < 3; p++) push_pkt(100, p, 1'b0);
    do_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
      axis_out.tready = ($urandom_range(0, 1) == 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_timeout act left=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    axis_out.tready = 1'b1;
    checks++;
    if (pkts_sent !== 3 || bytes_sent !== 300 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_stats act pkts=%0d bytes=%0d busy=%b required 3 300 0",
               pkts_sent, bytes_sent, busy);
    end
  endtask

  task automatic test_stop();
    int gap;
    int bub;
    int extra;
    cfg(0, 64, 64, 0, 4, MODE_COUNTER, 32'h0020, 1'b0);
    model_init(MODE_COUNTER, 32'h0020);
    push_pkt(64, 0, 1'b0);
    push_pkt(64, 1, 1'b0);
    axis_out.tready = 1'b1;
    do_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 1) break;
    end
    @(posedge clk); #1;
    axis_out.tready = 1'b0;
    gap = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (axis_out.tvalid) break;
      gap++;
    end
    checks++;
    if (gap !== 4) begin
      errors++;
      $display("FAIL stop_gap act=%0d required=4", gap);
    end
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || axis_out.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL stop_inflight act busy=%b tvalid=%b required 1 1", busy, axis_out.tvalid);
    end
    axis_out.tready = 1'b1;
    wait_drain(50, bub);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stop_timeout act left=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pkts_sent !== 2 || bytes_sent !== 128) begin
      errors++;
      $display("FAIL stop_end act busy=%b pkts=%0d bytes=%0d required 0 2 128",
               busy, pkts_sent, bytes_sent);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (axis_out.tvalid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL stop_no_pkt3 act valid_cycles=%0d required=0", extra);
    end
  endtask

  task automatic test_prbs_hdr();
    int bub;
    cfg(3, 128, 128, 0, 0, MODE_PRBS, 32'h0, 1'b1);
    model_init(MODE_PRBS, 32'h0);
    for (int p = 0; p < 3; p++) push_pkt(128, p, 1'b1);
    do_start();
    wait_drain(100, bub);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL prbs_timeout act left=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (pkts_sent !== 3 || bytes_sent !== 384) begin
      errors++;
      $display("FAIL prbs_stats act pkts=%0d bytes=%0d required 3 384", pkts_sent, bytes_sent);
    end
  endtask

  task automatic test_start_stop_same();
    int v;
    cfg(1, 64, 64, 0, 0, MODE_COUNTER, 32'h0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    stop  = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_busy act=%b required=0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    v = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (axis_out.tvalid || busy) v++;
    end
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL start_stop_norun act active_cycles=%0d required=0", v);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bub;
    mon_en = 1'b0;
    cfg(5, 128, 128, 0, 0, MODE_COUNTER, 32'h0, 1'b1);
    do_start();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (axis_out.tvalid && axis_out.tready) n++;
      if (n == 3) break;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL rmid_reach act beats=%0d required=3", n);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axis_out.tvalid !== 1'b0 || busy !== 1'b0 || pkts_sent !== 0 || bytes_sent !== 0) begin
      errors++;
      $display("FAIL rmid_abort act tvalid=%b busy=%b pkts=%0d bytes=%0d required 0 0 0 0",
               axis_out.tvalid, busy, pkts_sent, bytes_sent);
    end
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    cfg(2, 64, 64, 0, 0, MODE_COUNTER, 32'h0040, 1'b1);
    model_init(MODE_COUNTER, 32'h0040);
    push_pkt(64, 0, 1'b1);
    push_pkt(64, 1, 1'b1);
    do_start();
    wait_drain(50, bub);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_timeout act left=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (pkts_sent !== 2 || bytes_sent !== 128) begin
      errors++;
      $display("FAIL rmid_rerun act pkts=%0d bytes=%0d required 2 128", pkts_sent, bytes_sent);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    stop            = 1'b0;
    axis_out.tready = 1'b1;
    cfg(0, 64, 64, 0, 0, MODE_COUNTER, 32'h0, 1'b0);
    test_reset();
    mon_en = 1'b1;
    test_fixed_len();
    test_sweep();
    test_stall();
    test_stop();
    test_prbs_hdr();
    test_start_stop_same();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
